// File: rtl/alu_defs.sv
// Opcode encodings and flag bit positions shared by the CLA pipe and the ALU result mux.
package alu_defs;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_ADC = 2'b10,
      OP_SBC = 2'b11
   } alu_op_e;

   localparam int FLAG_C = 0;
   localparam int FLAG_V = 1;
   localparam int FLAG_Z = 2;
   localparam int FLAG_N = 3;

   // Subtract forms feed ~B into the adder.
   function automatic logic op_invert_b(input alu_op_e op);
      return (op == OP_SUB) || (op == OP_SBC);
   endfunction

   function automatic logic op_carry_in(input alu_op_e op, input logic cin);
      logic c;
      case (op)
         OP_ADD:  c = 1'b0;
         OP_SUB:  c = 1'b1;
         default: c = cin;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/cla_segment.sv
// SEG_W-bit combinational carry-lookahead adder; every carry is a flat sum of g/p products.
module cla_segment #(
   parameter int SEG_W = 8
) (
   input  logic [SEG_W-1:0] a,
   input  logic [SEG_W-1:0] b,
   input  logic             cin,
   output logic [SEG_W-1:0] sum,
   output logic             cout,
   output logic             cmsb
);

   logic [SEG_W-1:0] g;
   logic [SEG_W-1:0] p;
   logic [SEG_W:0]   c;
   logic             carry;
   logic             prop;

   assign g = a & b;
   assign p = a ^ b;

   // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin, expanded rather than rippled.
   always_comb begin
      c     = '0;
      carry = 1'b0;
      prop  = 1'b1;
      c[0]  = cin;
      for (int i = 0; i < SEG_W; i++) begin
         carry = 1'b0;
         prop  = 1'b1;
         for (int j = i; j >= 0; j--) begin
            carry = carry | (prop & g[j]);
            prop  = prop & p[j];
         end
         c[i+1] = carry | (prop & cin);
      end
   end

   assign sum  = p ^ c[SEG_W-1:0];
   assign cout = c[SEG_W];
   assign cmsb = c[SEG_W-1];

endmodule

// File: rtl/cla_adder_pipe.sv
// Pipelined CLA adder/subtractor, one register stage per SEG_W segment.
// Define CLA_PIPE_FLAGS_EN to build the N/Z/V flag logic; otherwise only C is reported.
module cla_adder_pipe
   import alu_defs::*;
#(
   parameter int WIDTH = 16,
   parameter int SEG_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       Op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Sum,
   output logic             Cout,
   output logic [3:0]       Flags
);

   localparam int NSEG = WIDTH / SEG_W;

   // Handshake: a beat moves on a cycle where valid & ready are both high at the
   // rising edge. The whole pipe advances together whenever the output slot is
   // empty or being drained, so a stalled result freezes every stage behind it.
   logic adv;
   logic accept;

   assign adv      = !out_valid || out_ready;
   assign in_ready = adv && !rst;
   assign accept   = in_valid && in_ready;

   alu_op_e          op_e;
   logic [WIDTH-1:0] b_eff;
   logic             cin_eff;

   assign op_e    = alu_op_e'(Op);
   assign b_eff   = op_invert_b(op_e) ? ~B : B;
   assign cin_eff = op_carry_in(op_e, Cin);

   logic             vld_q [NSEG];
   logic [WIDTH-1:0] a_q   [NSEG];
   logic [WIDTH-1:0] b_q   [NSEG];
   logic [WIDTH-1:0] s_q   [NSEG];
   logic             c_q   [NSEG];

   logic             vin   [NSEG];
   logic [WIDTH-1:0] a_in  [NSEG];
   logic [WIDTH-1:0] b_in  [NSEG];
   logic [WIDTH-1:0] s_in  [NSEG];
   logic [WIDTH-1:0] s_nx  [NSEG];
   logic             c_in  [NSEG];
   logic [SEG_W-1:0] seg_s [NSEG];
   logic [1:0]       seg_c [NSEG];

`ifdef CLA_PIPE_FLAGS_EN
   logic z_q  [NSEG];
   logic z_nx [NSEG];
   logic ovf_q;
`endif

   for (genvar k = 0; k < NSEG; k++) begin : g_stage
      if (k == 0) begin : g_head
         assign vin[k]  = accept;
         assign a_in[k] = A;
         assign b_in[k] = b_eff;
         assign s_in[k] = '0;
         assign c_in[k] = cin_eff;
      end else begin : g_tail
         assign vin[k]  = vld_q[k-1];
         assign a_in[k] = a_q[k-1];
         assign b_in[k] = b_q[k-1];
         assign s_in[k] = s_q[k-1];
         assign c_in[k] = c_q[k-1];
      end

      cla_segment #(.SEG_W(SEG_W)) u_seg (
         .a    (a_in[k][k*SEG_W +: SEG_W]),
         .b    (b_in[k][k*SEG_W +: SEG_W]),
         .cin  (c_in[k]),
         .sum  (seg_s[k]),
         .cout (seg_c[k][1]),
         .cmsb (seg_c[k][0])
      );

      // Splice this stage's segment into the partial result carried with the beat.
      assign s_nx[k] = (s_in[k] & ~(WIDTH'({SEG_W{1'b1}}) << (k*SEG_W)))
                     | (WIDTH'(seg_s[k]) << (k*SEG_W));

`ifdef CLA_PIPE_FLAGS_EN
      if (k == 0) begin : g_z_head
         assign z_nx[k] = (seg_s[k] == '0);
      end else begin : g_z_tail
         assign z_nx[k] = z_q[k-1] && (seg_s[k] == '0);
      end
`endif
   end

   // Data registers load only with a valid beat, so the output holds its last result.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < NSEG; k++) begin
            vld_q[k] <= 1'b0;
            a_q[k]   <= '0;
            b_q[k]   <= '0;
            s_q[k]   <= '0;
            c_q[k]   <= 1'b0;
`ifdef CLA_PIPE_FLAGS_EN
            z_q[k]   <= 1'b0;
`endif
         end
`ifdef CLA_PIPE_FLAGS_EN
         ovf_q <= 1'b0;
`endif
      end else if (adv) begin
         for (int k = 0; k < NSEG; k++) begin
            vld_q[k] <= vin[k];
            if (vin[k]) begin
               a_q[k] <= a_in[k];
               b_q[k] <= b_in[k];
               s_q[k] <= s_nx[k];
               c_q[k] <= seg_c[k][1];
`ifdef CLA_PIPE_FLAGS_EN
               z_q[k] <= z_nx[k];
`endif
            end
         end
`ifdef CLA_PIPE_FLAGS_EN
         if (vin[NSEG-1]) begin
            ovf_q <= seg_c[NSEG-1][1] ^ seg_c[NSEG-1][0];
         end
`endif
      end
   end

   assign out_valid = vld_q[NSEG-1];
   assign Sum       = s_q[NSEG-1];
   assign Cout      = c_q[NSEG-1];

   always_comb begin
      Flags         = '0;
      Flags[FLAG_C] = Cout;
`ifdef CLA_PIPE_FLAGS_EN
      Flags[FLAG_N] = Sum[WIDTH-1];
      Flags[FLAG_Z] = z_q[NSEG-1];
      Flags[FLAG_V] = ovf_q;
`endif
   end

endmodule

// File: tb/tb_cla_adder_pipe.sv
// Directed bench for cla_adder_pipe (WIDTH=16, SEG_W=8); expectations are hand-computed NZVC/Sum values.
module tb_cla_adder_pipe;
   import alu_defs::*;

   localparam int W  = 16;
   localparam int EW = 4 + 1 + W;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [1:0]   Op;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic         Cin;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] Sum;
   logic         Cout;
   logic [3:0]   Flags;

   int tests_run = 0;
   int fails     = 0;

   logic [EW-1:0] exp_q[$];

   typedef struct {
      logic [1:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic [W-1:0] sum;
      logic [3:0]   nzvc;
   } vec_t;

   vec_t vecs[12];

   cla_adder_pipe #(.WIDTH(W), .SEG_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .Op        (Op),
      .A         (A),
      .B         (B),
      .Cin       (Cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .Sum       (Sum),
      .Cout      (Cout),
      .Flags     (Flags)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [3:0] mask_flags(input logic [3:0] f);
`ifdef CLA_PIPE_FLAGS_EN
      return f;
`else
      return {3'b000, f[0]};
`endif
   endfunction

   // ---------------- driver tasks ----------------
   task automatic send_beat(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic cin, input logic [W-1:0] sum, input logic [3:0] nzvc);
      int guard;
      @(negedge clk);
      in_valid = 1'b1;
      Op       = op;
      A        = a;
      B        = b;
      Cin      = cin;
      exp_q.push_back({mask_flags(nzvc), nzvc[0], sum});
      guard = 0;
      while (!in_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 50) check("accept_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while (exp_q.size() != 0 && guard < 50) begin
         @(posedge clk);
         guard++;
      end
      check("drain", exp_q.size(), 0);
   endtask

   // ---------------- scoreboard / monitor ----------------
   logic         stalled_prev = 1'b0;
   logic [W-1:0] held_sum;

   always @(negedge clk) begin
      logic [EW-1:0] e;
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("sum",   Sum,   e[W-1:0]);
            check("cout",  Cout,  e[W]);
            check("flags", Flags, e[EW-1:W+1]);
         end
      end
      if (!rst && out_valid && !out_ready) begin
         check("stall_in_ready", in_ready, 0);
         if (stalled_prev) check("stall_hold", Sum, held_sum);
         held_sum     = Sum;
         stalled_prev = 1'b1;
      end else begin
         stalled_prev = 1'b0;
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      vecs = '{
         '{OP_ADD, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 4'b0000},
         '{OP_ADD, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 4'b1010},
         '{OP_ADD, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 4'b0101},
         '{OP_SUB, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 4'b1000},
         '{OP_SUB, 16'h1234, 16'h1234, 1'b0, 16'h0000, 4'b0101},
         '{OP_SBC, 16'h0005, 16'h0003, 1'b0, 16'h0001, 4'b0001},
         '{OP_ADC, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 4'b0101},
         '{OP_ADD, 16'h8000, 16'h8000, 1'b0, 16'h0000, 4'b0111},
         '{OP_SUB, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 4'b0011},
         '{OP_ADC, 16'h0001, 16'h0001, 1'b1, 16'h0003, 4'b0000},
         '{OP_ADD, 16'h0010, 16'h0020, 1'b1, 16'h0030, 4'b0000},
         '{OP_SUB, 16'h0003, 16'h0001, 1'b0, 16'h0002, 4'b0001}
      };

      rst       = 1'b1;
      in_valid  = 1'b0;
      Op        = 2'b00;
      A         = '0;
      B         = '0;
      Cin       = 1'b0;
      out_ready = 1'b1;

      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready",  in_ready,  0);
      check("rst_out_valid", out_valid, 0);
      check("rst_sum",       Sum,       0);
      check("rst_cout",      Cout,      0);
      check("rst_flags",     Flags,     0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("post_rst_in_ready", in_ready, 1);

      // Single beat with latency check: valid one cycle after the accepting edge.
      send_beat(vecs[0].op, vecs[0].a, vecs[0].b, vecs[0].cin, vecs[0].sum, vecs[0].nzvc);
      check("lat_edge0", out_valid, 0);
      @(posedge clk);
      #1;
      check("lat_edge1", out_valid, 1);
      drain();

      // Remaining directed vectors back-to-back.
      for (int i = 1; i < 12; i++) begin
         send_beat(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].nzvc);
      end
      drain();

      // Four beats with a three-cycle output stall mid-stream.
      fork
         begin
            for (int i = 1; i <= 4; i++) begin
               send_beat(OP_ADD, W'(i), W'(i), 1'b0, W'(2 * i), 4'b0000);
            end
         end
         begin
            int g;
            g = 0;
            do begin
               @(posedge clk);
               #1;
               g++;
            end while (!out_valid && g < 20);
            check("stall_start", out_valid, 1);
            #1;
            out_ready = 1'b0;
            repeat (3) @(posedge clk);
            #2;
            out_ready = 1'b1;
         end
      join
      drain();

      // Reset while a beat is in flight: it must never appear.
      send_beat(OP_ADD, 16'h1111, 16'h2222, 1'b0, 16'h3333, 4'b0000);
      void'(exp_q.pop_back());
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_sum",       Sum,       0);
      check("mid_rst_flags",     Flags,     0);
      check("mid_rst_in_ready",  in_ready,  0);
      rst = 1'b0;
      #1;
      check("mid_rst_release_ready", in_ready, 1);
      repeat (2) @(posedge clk);
      #1;
      check("mid_rst_no_result", out_valid, 0);
      send_beat(OP_SUB, 16'h0100, 16'h0001, 1'b0, 16'h00FF, 4'b0001);
      drain();

      repeat (2) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule

// File: doc/cla_adder_pipe.md
# cla_adder_pipe

Parametrised, pipelined carry-lookahead adder/subtractor for the ALU datapath. It is the next generation of the team's 8-bit combinational CLA. It splits a WIDTH-bit operation into SEG_W-bit lookahead segments, with one register stage per segment, and adds a valid/ready handshake, subtract and carry-chain modes, and status flags. It sits between operand select and the ALU result mux, and sustains one operation per clock.

## Interface
- WIDTH, 16: operand/result width; must be a multiple of SEG_W, ≥ SEG_W.
- SEG_W, 8: lookahead segment width; NSEG = WIDTH/SEG_W pipeline stages.
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block accepts the beat this cycle.
- Op  in  2  00 ADD, 01 SUB, 10 ADC, 11 SBC.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- Cin  in  1  carry input, used by ADC/SBC only.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts the result.
- Sum  out  WIDTH  result.
- Cout  out  1  carry out of the MSB.
- Flags  out  4  {N, Z, V, C}; C equals Cout.

## Operation
- Effective operands per Op:
  - ADD: A + B + 0.
  - SUB: A + ~B + 1.
  - ADC: A + B + Cin.
  - SBC: A + ~B + Cin.
  - All arithmetic is modulo 2^WIDTH. For SUB/SBC, C=1 means no borrow.
- Stage k (0..NSEG-1) computes segment k with a full SEG_W-bit lookahead using the registered carry from stage k-1; stage 0 uses the effective carry-in.
- Operand segments not yet consumed, and result segments already produced, travel skewed through the stage registers with their beat.
- Global advance: adv = !out_valid | out_ready. All stage registers and valid bits shift only when adv=1; in_ready = adv & !rst.
- Beat accepted when in_valid & in_ready. Bubbles propagate as valid=0.
- Flags, computed on the final stage:
  - N = Sum[WIDTH-1].
  - Z = (Sum == 0), accumulated per segment along the pipe.
  - V = carry into MSB XOR carry out of MSB.
  - C = Cout.
- Op and Cin are sampled only at acceptance.

## Timing
- Reset: every valid bit clears.
  - out_valid=0; Sum, Cout and Flags = 0.
  - in_ready=0 while rst=1, and 1 in the first cycle after reset.
- Latency: a beat accepted at edge t gives out_valid=1 after edge t+NSEG-1 when never stalled. For NSEG=2, the result is visible one cycle after acceptance.
- Throughput: 1 beat/clk when out_ready stays high.
- Stall: out_valid=1 & out_ready=0 freezes the whole pipe.
  - Sum/Cout/Flags stay stable and in_ready=0.
  - No beat is dropped or duplicated.
- Simultaneous output handshake and input accept in the same cycle is legal and is the full-throughput case.
- Reset mid-operation discards all in-flight beats; no partial result is ever presented.
- out_valid must not drop without out_ready. Sum is don't-care when out_valid=0 but holds its last value (no glitching to X).

## Configuration
- CLA_PIPE_FLAGS_EN defined:
  - N/Z/V are computed and registered as above.
  - The Z accumulator is carried through the stages.
- Not defined:
  - Flags[3:1] (N, Z, V) are tied to 0; Flags[0] still equals Cout.
  - No zero-accumulate or overflow logic is synthesised.
  - Sum, Cout and handshake behaviour are identical in both builds.

## Structure
- Shared package/include `alu_defs`: Op encodings (OP_ADD, OP_SUB, OP_ADC, OP_SBC) and flag bit indices (FLAG_C=0, FLAG_V=1, FLAG_Z=2, FLAG_N=3), shared with the ALU result mux.
- One sub-module: `cla_segment`.
  - Parametrised SEG_W-bit combinational lookahead.
  - Inputs: a, b, cin. Outputs: sum, cout, and the carry into its MSB (for V).
  - Instantiated NSEG times via generate.
- The top level holds the skew registers, valid bits, advance logic and flag registers.

## Test plan
All cases use WIDTH=16, SEG_W=8.
- Carry across segment: ADD 0x00FF + 0x0001 → Sum=0x0100, C=0, Z=0, out_valid exactly one cycle after acceptance.
- Signed overflow: ADD 0x7FFF + 0x0001 → Sum=0x8000, V=1, N=1, C=0. ADD 0xFFFF + 0x0001 → Sum=0x0000, C=1, Z=1, V=0.
- Subtract/borrow: SUB 0x0000 − 0x0001 → Sum=0xFFFF, C=0, N=1. SUB 0x1234 − 0x1234 → 0x0000, C=1, Z=1. SBC 0x0005, 0x0003, Cin=0 → 0x0001. ADC 0xFFFF + 0x0000, Cin=1 → 0x0000, C=1.
- Back-to-back with stall: four consecutive beats (0x0001+0x0001 .. 0x0004+0x0004) with out_ready low for 3 cycles mid-stream → results 0x0002, 0x0004, 0x0006, 0x0008 in order, no loss or duplication; in_ready=0 during the stall.
- Reset mid-flight: accept a beat, assert rst for one cycle → out_valid stays 0, Sum=0, Flags=0; the next accepted beat completes normally.
- Build without CLA_PIPE_FLAGS_EN: rerun the overflow case → Sum and C unchanged, Flags[3:1]=000.
